dcache_read_return: RTL and testbench

//  Read-side counterpart of the L1 dcache write-merge path.
//  - Serves CPU loads from a one-entry line buffer (last line read).
//  - On a buffer miss, fetches the 128-bit line from the dcache array/L2,

---
 rtl/lc3b_types.sv | 21 ++
 rtl/data_read_select.sv | 25 ++
 rtl/dcache_read_return.sv | 154 +++++++++++++++
 tb/tb_dcache_read_return.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b cache types.
// Provides the word, line and offset types used by both dcache datapaths,
// plus the tag type and state encoding for the read-return path.
package lc3b_types;

  localparam int DCACHE_LINE_BITS = 128;
  localparam int LINE_WORDS       = 8;
  localparam int BYTE_LANES       = 2;

  typedef logic [15:0]                 lc3b_word;
  typedef logic [DCACHE_LINE_BITS-1:0] pmem_L1_bus;
  typedef logic [2:0]                  dcache_offset;
  typedef logic [11:0]                 dcache_tag;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_RESP
  } dcache_rd_state_t;

endpackage

// File: rtl/data_read_select.sv
// Combinational lane extractor.
// This is the read-side mirror of the write-merge logic. It picks the
// addressed 16-bit word out of a line and zeroes any byte lane that was
// not requested.
//   line        in  128  source line (fetched line or buffered line)
//   offset      in  3    word index within the line
//   byte_enable in  2    [0]=low byte, [1]=high byte
//   word        out 16   selected, lane-masked word
module data_read_select
  import lc3b_types::*;
(
  input  pmem_L1_bus   line,
  input  dcache_offset offset,
  input  logic [1:0]   byte_enable,
  output lc3b_word     word
);

  lc3b_word w;
  assign w = line[16*offset +: 16];

  for (genvar b = 0; b < BYTE_LANES; b++) begin : g_lane
    assign word[8*b +: 8] = byte_enable[b] ? w[8*b +: 8] : 8'h00;
  end

endmodule

// File: rtl/dcache_read_return.sv
// L1 dcache read-return path.
// CPU loads are served from a one-entry line buffer. A miss fetches the
// line from the array/L2. Snooped writes and flush invalidate the buffer,
// so a load never returns stale data.
//   clk, reset_n                    clock / async active-low reset
//   mem_read, mem_address,
//   mem_byte_enable                 CPU load request (held until mem_resp)
//   mem_rdata, mem_resp             returned word, one-cycle valid pulse
//   line_read, line_address         line fetch request, held until line_resp
//   line_rdata, line_resp           fetched line and its completion pulse
//   snoop_write, snoop_address      committing write seen elsewhere
//   flush                           invalidate the line buffer
module dcache_read_return
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  lc3b_word    mem_address,
  input  logic [1:0]  mem_byte_enable,
  output lc3b_word    mem_rdata,
  output logic        mem_resp,
  output logic        line_read,
  output lc3b_word    line_address,
  input  pmem_L1_bus  line_rdata,
  input  logic        line_resp,
  input  logic        snoop_write,
  input  lc3b_word    snoop_address,
  input  logic        flush
);

  dcache_rd_state_t state, state_next;

  logic         buf_valid;
  dcache_tag    buf_tag;
  pmem_L1_bus   buf_line;

  // Request copy taken at acceptance; the fetch path only uses this copy.
  dcache_tag    req_tag;
  dcache_offset req_off;
  logic [1:0]   req_be;
  // Set when the line being fetched was written or flushed mid-fetch.
  logic         fetch_poison;

  dcache_tag    addr_tag, snoop_tag;
  logic         kill_buf, hit, snoop_fetch;
  logic         accept_hit, accept_miss, fill;

  pmem_L1_bus   sel_line;
  dcache_offset sel_off;
  logic [1:0]   sel_be;
  lc3b_word     sel_word;

  // Sub-line address bits carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{mem_address[0], snoop_address[3:0]};

  assign addr_tag  = mem_address[15:4];
  assign snoop_tag = snoop_address[15:4];

  // A same-cycle invalidation beats a hit: the request becomes a miss.
  assign kill_buf    = flush | (snoop_write & (snoop_tag == buf_tag));
  assign hit         = buf_valid & (buf_tag == addr_tag) & ~kill_buf;
  assign snoop_fetch = flush | (snoop_write & (snoop_tag == req_tag));

  assign mem_resp = (state == RD_RESP);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RD_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    fill        = 1'b0;
    case (state)
      RD_IDLE: begin
        if (mem_read) begin
          if (hit) begin
            accept_hit = 1'b1;
            state_next = RD_RESP;
          end else begin
            accept_miss = 1'b1;
            state_next  = RD_FETCH;
          end
        end
      end
      RD_FETCH: begin
        if (line_resp) begin
          fill       = 1'b1;
          state_next = RD_RESP;
        end
      end
      RD_RESP:  state_next = RD_IDLE;
      default:  state_next = RD_IDLE;
    endcase
  end

  // One extractor serves both paths: buffer on a hit, bus line on a fill.
  assign sel_line = (state == RD_FETCH) ? line_rdata : buf_line;
  assign sel_off  = (state == RD_FETCH) ? req_off    : mem_address[3:1];
  assign sel_be   = (state == RD_FETCH) ? req_be     : mem_byte_enable;

  data_read_select u_sel (
    .line        (sel_line),
    .offset      (sel_off),
    .byte_enable (sel_be),
    .word        (sel_word)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rdata    <= '0;
      line_read    <= 1'b0;
      line_address <= '0;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_line     <= '0;
      req_tag      <= '0;
      req_off      <= '0;
      req_be       <= '0;
      fetch_poison <= 1'b0;
    end else begin
      if (accept_hit || fill) mem_rdata <= sel_word;

      if (accept_miss) begin
        line_read    <= 1'b1;
        line_address <= {addr_tag, 4'h0};
        req_tag      <= addr_tag;
        req_off      <= mem_address[3:1];
        req_be       <= mem_byte_enable;
        fetch_poison <= 1'b0;
      end else if (state == RD_FETCH) begin
        if (snoop_fetch) fetch_poison <= 1'b1;
        if (line_resp)   line_read    <= 1'b0;
      end

      // The load still gets the fetched data, but a line touched mid-fetch
      // is not kept as valid.
      if (fill) begin
        buf_line  <= line_rdata;
        buf_tag   <= req_tag;
        buf_valid <= ~(fetch_poison | snoop_fetch);
      end else if (kill_buf) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_read_return.sv
module tb_dcache_read_return;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         line_read;
  logic [15:0]  line_address;
  logic [127:0] line_rdata;
  logic         line_resp;
  logic         snoop_write;
  logic [15:0]  snoop_address;
  logic         flush;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  dcache_read_return dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .line_read(line_read), .line_address(line_address),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .snoop_write(snoop_write), .snoop_address(snoop_address), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every mem_resp pops one expected word.
  always @(negedge clk) begin
    if (reset_n && mem_resp) begin
      if (sb.size() == 0) check("unexpected_resp", 32'(mem_resp), 32'd0);
      else check("rdata", 32'(mem_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic pulse_snoop(input logic [15:0] a);
    @(negedge clk); snoop_write = 1'b1; snoop_address = a;
    @(negedge clk); snoop_write = 1'b0;
  endtask

  // One load. Serves the fetch (line_resp on the third line_read cycle),
  // optionally snoops the line mid-fetch or flushes alongside the request.
  task automatic do_read(input logic [15:0] a, input logic [1:0] be, input logic [127:0] line,
                         input bit miss, input bit snoop_in_fetch, input bit flush_req,
                         input logic [15:0] exp);
    int n, fc;
    bit got;
    n = 0; fc = 0; got = 0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = a; mem_byte_enable = be; flush = flush_req;
    sb.push_back(exp);
    while (!got && n < 40) begin
      @(negedge clk);
      n++; line_resp = 1'b0; flush = 1'b0; snoop_write = 1'b0;
      if (mem_resp) got = 1;
      else if (line_read) begin
        fc++;
        if (fc == 1) begin
          check("line_address", 32'(line_address), 32'({a[15:4], 4'h0}));
          if (snoop_in_fetch) begin snoop_write = 1'b1; snoop_address = a; end
        end
        if (fc == 3) begin
          check("line_addr_hold", 32'(line_address), 32'({a[15:4], 4'h0}));
          line_rdata = line; line_resp = 1'b1;
        end
      end
    end
    mem_read = 1'b0; line_resp = 1'b0;
    check("resp_seen", 32'(got), 32'd1);
    check("fetch_taken", 32'(fc != 0), 32'(miss));
    if (!miss) check("hit_latency", 32'(n), 32'd1);
  endtask

  logic [127:0] l1, l2, l3, l3b, l4;

  initial begin
    int nresp;
    l1  = {16'hA55A, 16'h6666, 16'h5555, 16'h4444, 16'hBEEF, 16'h2222, 16'h1111, 16'h1234};
    l2  = {16'hA55A, 16'h6666, 16'h5555, 16'h4444, 16'hBEEF, 16'h2222, 16'h1111, 16'h4321};
    l3  = {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'hCAFE, 16'h0001, 16'h0000};
    l3b = {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'hD00D, 16'h0001, 16'h0000};
    l4  = {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0BAD, 16'h0002, 16'h0001, 16'h0000};

    reset_n = 1'b0; mem_read = 1'b0; mem_address = '0; mem_byte_enable = '0;
    line_rdata = '0; line_resp = 1'b0; snoop_write = 1'b0; snoop_address = '0; flush = 1'b0;
    #23;
    check("rst_mem_resp",  32'(mem_resp), 32'd0);
    check("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    check("rst_line_read", 32'(line_read), 32'd0);
    check("rst_line_addr", 32'(line_address), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // cold miss, then hits on the buffered line
    do_read(16'h1236, 2'b11, l1, 1, 0, 0, 16'hBEEF);
    do_read(16'h123E, 2'b01, l1, 0, 0, 0, 16'h005A);
    do_read(16'h1230, 2'b10, l1, 0, 0, 0, 16'h1200);
    do_read(16'h1230, 2'b00, l1, 0, 0, 0, 16'h0000);

    // unrelated snoop keeps the buffer; matching snoop forces a refetch
    pulse_snoop(16'h2000);
    do_read(16'h1232, 2'b11, l1, 0, 0, 0, 16'h1111);
    pulse_snoop(16'h1238);
    do_read(16'h1230, 2'b11, l2, 1, 0, 0, 16'h4321);

    // snoop of the line under fetch: data returned, buffer left invalid
    do_read(16'h4564, 2'b11, l3,  1, 1, 0, 16'hCAFE);
    do_read(16'h4564, 2'b11, l3b, 1, 0, 0, 16'hD00D);
    // flush in the same cycle as a would-be hit turns it into a miss
    do_read(16'h4566, 2'b11, l4,  1, 0, 1, 16'h0BAD);
    do_read(16'h4566, 2'b01, l4,  0, 0, 0, 16'h00AD);

    // reset in the middle of a fetch
    @(negedge clk); mem_read = 1'b1; mem_address = 16'h7770; mem_byte_enable = 2'b11;
    nresp = 0;
    while (!line_read && nresp < 10) begin @(negedge clk); nresp++; end
    check("midfetch_line_read", 32'(line_read), 32'd1);
    reset_n = 1'b0; #1;
    check("rst_drops_line_read", 32'(line_read), 32'd0);
    mem_read = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); line_rdata = l1; line_resp = 1'b1;
    @(negedge clk); line_resp = 1'b0;
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_resp) nresp++;
      @(negedge clk);
    end
    check("late_line_resp_ignored", 32'(nresp), 32'd0);
    check("late_line_read", 32'(line_read), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
